mem_bus_arbiter: RTL

- Two-master, one-slave arbiter for the shared memory/IO bus.
- Master 0 is the multi-cycle CPU (its mem_w / Addr_out / data_out / MIO_ready side); master 1 is a secondary requester (VGA fetch or DMA).
- Serialises single-word transactions onto one stb/ack slave bus using round-robin fairness, registered responses, and a timeout that returns an error instead of hanging the CPU.

---
 rtl/mem_bus_arbiter_pkg.sv | 18 +
 rtl/mem_bus_arbiter_rr.sv | 36 +++
 rtl/mem_bus_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory/IO bus arbiter: state encoding,
// timeout counter width and default response constants.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER0 = 2'd1;
    localparam logic [1:0] ST_XFER1 = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int          CNT_W        = 8;
    localparam int          DEF_TIMEOUT  = 255;
    localparam logic [31:0] DEF_ERR_DATA = 32'h0000_0000;

    function automatic logic is_xfer(input logic [1:0] st);
        return (st == ST_XFER0) || (st == ST_XFER1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Two-request round-robin picker. The pointer names the master that wins a tie
// and moves to the other master whenever a grant is taken (update_i).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i && (gnt_o != 2'b00)) begin
            ptr_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises single-word transactions from the CPU (m0) and a secondary master
// (m1) onto one stb/ack slave bus, with registered responses and an ack timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = DEF_TIMEOUT,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              m1_err,
    output logic              s_stb,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ack,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              ready0_q, ready1_q;
    logic              err0_q, err1_q;

    logic [1:0] arb_gnt;
    logic       arb_update;
    logic       xfer;
    logic       sel1;
    logic       cur_we;
    logic       timeout_hit;
    logic       finishing;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({m1_req, m0_req}),
        .update_i (arb_update),
        .gnt_o    (arb_gnt)
    );

    assign xfer        = is_xfer(state_q);
    assign sel1        = (state_q == ST_XFER1);
    assign cur_we      = sel1 ? m1_we : m0_we;
    assign timeout_hit = xfer && (cnt_q == TIMEOUT_C);
    // Ack takes priority over a timeout landing in the same cycle.
    assign finishing   = xfer && (s_ack || timeout_hit);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        arb_update = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (m0_req || m1_req) begin
                    arb_update = 1'b1;
                    state_d    = arb_gnt[1] ? ST_XFER1 : ST_XFER0;
                end
            end
            ST_XFER0, ST_XFER1: begin
                cnt_d = cnt_q + 1'b1;
                if (s_ack || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            // Ready and err are only ever high for the single RESP cycle.
            ready0_q <= finishing && !sel1;
            ready1_q <= finishing && sel1;
            err0_q   <= finishing && !sel1 && !s_ack;
            err1_q   <= finishing && sel1 && !s_ack;
            if (finishing && !sel1) begin
                if (!s_ack) begin
                    rdata0_q <= ERR_DATA;
                end else if (!cur_we) begin
                    rdata0_q <= s_rdata;
                end
            end
            if (finishing && sel1) begin
                if (!s_ack) begin
                    rdata1_q <= ERR_DATA;
                end else if (!cur_we) begin
                    rdata1_q <= s_rdata;
                end
            end
        end
    end

    assign s_stb   = xfer;
    assign s_we    = xfer && cur_we;
    assign s_addr  = xfer ? (sel1 ? m1_addr : m0_addr) : '0;
    assign s_wdata = xfer ? (sel1 ? m1_wdata : m0_wdata) : '0;
    assign grant   = {state_q == ST_XFER1, state_q == ST_XFER0};
    assign busy    = (state_q != ST_IDLE);

    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign m0_ready = ready0_q;
    assign m1_ready = ready1_q;
    assign m0_err   = err0_q;
    assign m1_err   = err1_q;

endmodule
